// File: rtl/bus_sync_pkg.sv
// bus_sync_pkg: shared FSM state type, widths and counter-sizing helpers for bus_sync_rx.
package bus_sync_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        CAPTURE,
        COMPARE,
        DONE,
        ABORT
    } state_e;

    localparam int MISMATCH_CNT_WIDTH = 8;

    // The settle counter must hold SETTLE_CYCLES itself because retries reload the full count.
    function automatic int settle_cnt_width(input int settle_cycles);
        return $clog2(settle_cycles + 1);
    endfunction

    function automatic int retry_cnt_width(input int max_retry);
        return $clog2(max_retry + 1);
    endfunction

endpackage

// File: rtl/bus_sync_rx_tgl_sync.sv
// bus_sync_rx_tgl_sync: SYNC_STAGES-deep synchronizer for the request toggle.
module bus_sync_rx_tgl_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/bus_sync_rx.sv
// bus_sync_rx: destination-side responder of the toggle/ack bus synchronizer.
// Define BUS_SYNC_RX_STABLE_CHECK_EN to add double-sampling with retry, abort and error reporting.
module bus_sync_rx
    import bus_sync_pkg::*;
#(
    parameter int BUS_SIZE      = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int SETTLE_CYCLES = 4,
    parameter int MAX_RETRY     = 3
) (
    input  logic                          out_clk,
    input  logic                          out_reset_n,
    input  logic                          req_tgl,
    input  logic [BUS_SIZE-1:0]           in_data,
    output logic [BUS_SIZE-1:0]           out_data,
    output logic                          out_valid,
    output logic                          ack_tgl,
    output logic                          stable_err,
    output logic [MISMATCH_CNT_WIDTH-1:0] mismatch_cnt
);

    localparam int SW = settle_cnt_width(SETTLE_CYCLES);
    localparam int RW = retry_cnt_width(MAX_RETRY);
    localparam logic [SW-1:0] SETTLE_LOAD   = SW'(SETTLE_CYCLES - 1);
    localparam logic [SW-1:0] SETTLE_RELOAD = SW'(SETTLE_CYCLES);
    localparam logic [RW-1:0] RETRY_LAST    = RW'(MAX_RETRY - 1);
    localparam logic [MISMATCH_CNT_WIDTH-1:0] MM_ONE = MISMATCH_CNT_WIDTH'(1);

    logic                req_s;
    logic [BUS_SIZE-1:0] data_s;
    logic [BUS_SIZE-1:0] data_sync_q [SYNC_STAGES];
    logic [BUS_SIZE-1:0] data_sync_d [SYNC_STAGES];

    state_e                        state_q, state_d;
    logic [SW-1:0]                 settle_cnt_q, settle_cnt_d;
    logic [RW-1:0]                 retry_cnt_q, retry_cnt_d;
    logic                          seen_tgl_q, seen_tgl_d;
    logic [BUS_SIZE-1:0]           sample_q, sample_d;
    logic [BUS_SIZE-1:0]           out_data_q, out_data_d;
    logic                          out_valid_q, out_valid_d;
    logic                          ack_tgl_q, ack_tgl_d;
    logic                          stable_err_q, stable_err_d;
    logic [MISMATCH_CNT_WIDTH-1:0] mismatch_cnt_q, mismatch_cnt_d;

    bus_sync_rx_tgl_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_req_sync (
        .clk  (out_clk),
        .rst_n(out_reset_n),
        .d    (req_tgl),
        .q    (req_s)
    );

    // The bus is quasi-static, so a plain flop chain suffices; stability is judged by the FSM.
    always_comb begin
        data_sync_d[0] = in_data;
        for (int i = 1; i < SYNC_STAGES; i++) data_sync_d[i] = data_sync_q[i-1];
    end

    always_ff @(posedge out_clk) begin
        for (int i = 0; i < SYNC_STAGES; i++) data_sync_q[i] <= out_reset_n ? data_sync_d[i] : '0;
    end

    assign data_s = data_sync_q[SYNC_STAGES-1];

    // Completion outputs are computed on the transition into DONE/ABORT so they appear
    // registered at the same edge the decision is made.
    always_comb begin
        state_d        = state_q;
        settle_cnt_d   = settle_cnt_q;
        retry_cnt_d    = retry_cnt_q;
        seen_tgl_d     = seen_tgl_q;
        sample_d       = sample_q;
        out_data_d     = out_data_q;
        out_valid_d    = 1'b0;
        ack_tgl_d      = ack_tgl_q;
        stable_err_d   = stable_err_q;
        mismatch_cnt_d = mismatch_cnt_q;
        case (state_q)
            IDLE: begin
                if (req_s != seen_tgl_q) begin
                    seen_tgl_d   = req_s;
                    settle_cnt_d = SETTLE_LOAD;
                    if (SETTLE_CYCLES == 1) state_d = CAPTURE;
                    else state_d = SETTLE;
                end
            end
            SETTLE: begin
                settle_cnt_d = settle_cnt_q - 1'b1;
                if (settle_cnt_q <= 1) state_d = CAPTURE;
            end
            CAPTURE: begin
                sample_d = data_s;
`ifdef BUS_SYNC_RX_STABLE_CHECK_EN
                state_d = COMPARE;
`else
                out_data_d  = data_s;
                out_valid_d = 1'b1;
                ack_tgl_d   = ~ack_tgl_q;
                state_d     = DONE;
`endif
            end
`ifdef BUS_SYNC_RX_STABLE_CHECK_EN
            COMPARE: begin
                if (sample_q == data_s) begin
                    out_data_d  = sample_q;
                    out_valid_d = 1'b1;
                    ack_tgl_d   = ~ack_tgl_q;
                    state_d     = DONE;
                end else begin
                    mismatch_cnt_d = (mismatch_cnt_q == '1) ? mismatch_cnt_q : mismatch_cnt_q + MM_ONE;
                    retry_cnt_d    = retry_cnt_q + 1'b1;
                    if (retry_cnt_q == RETRY_LAST) begin
                        stable_err_d = 1'b1;
                        ack_tgl_d    = ~ack_tgl_q;
                        state_d      = ABORT;
                    end else begin
                        settle_cnt_d = SETTLE_RELOAD;
                        state_d      = SETTLE;
                    end
                end
            end
            ABORT: begin
                retry_cnt_d = '0;
                state_d     = IDLE;
            end
`endif
            DONE: begin
                retry_cnt_d = '0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge out_clk) begin
        if (!out_reset_n) begin
            state_q        <= IDLE;
            settle_cnt_q   <= '0;
            retry_cnt_q    <= '0;
            seen_tgl_q     <= 1'b0;
            sample_q       <= '0;
            out_data_q     <= '0;
            out_valid_q    <= 1'b0;
            ack_tgl_q      <= 1'b0;
            stable_err_q   <= 1'b0;
            mismatch_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            settle_cnt_q   <= settle_cnt_d;
            retry_cnt_q    <= retry_cnt_d;
            seen_tgl_q     <= seen_tgl_d;
            sample_q       <= sample_d;
            out_data_q     <= out_data_d;
            out_valid_q    <= out_valid_d;
            ack_tgl_q      <= ack_tgl_d;
            stable_err_q   <= stable_err_d;
            mismatch_cnt_q <= mismatch_cnt_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign ack_tgl   = ack_tgl_q;
`ifdef BUS_SYNC_RX_STABLE_CHECK_EN
    assign stable_err   = stable_err_q;
    assign mismatch_cnt = mismatch_cnt_q;
`else
    assign stable_err   = 1'b0;
    assign mismatch_cnt = '0;
`endif

endmodule
